fwd_scoreboard: RTL
===================

// Module: fwd_scoreboard
// PURPOSE
//   Parametrised forwarding/hazard unit for the pipelined core. Tracks the destination register
//   of every in-flight instruction in a DEPTH-entry shift scoreboard that advances each cycle.
//   For each of NPORTS decode-stage source operands it selects the youngest in-flight producer
//   or the register file. It detects load-use hazards, inserts bubbles and counts stall cycles.
// PARAMETERS
//   REG_AW      5   register address width; register 0 is hard-wired zero
//   NPORTS      2   number of decode source operands looked up
//   DEPTH       3   scoreboard stages beyond decode (1=ID/EX, 2=EX/MEM, 3=MEM/WB)
//   LOAD_READY  2   lowest stage from which a load result can be forwarded to an advancing consumer
//   CNT_W      16   stall counter width
//   SEL_W  $clog2(DEPTH+1)   forward-select width (localparam)
// PORTS
//   clk          in   1               clock, all state on rising edge
//   rst_n        in   1               synchronous active-low reset
//   id_valid     in   1               decode slot holds a real instruction
//   id_rd        in   REG_AW          decode destination register
//   id_regwrite  in   1               decode instruction writes id_rd
//   id_is_load   in   1               decode instruction is a load
//   id_src       in   NPORTS*REG_AW   source registers, port p at [p*REG_AW +: REG_AW]
//   id_src_used  in   NPORTS          port p is actually read by the decode instruction
//   flush        in   1               squash decode instruction (bubble enters stage 1)
//   flush_all    in   1               squash decode and every scoreboard stage
//   fwd_sel      out  NPORTS*SEL_W    per port: 0=register file, k=result of stage k
//   stall        out  1               hold PC and IF/ID; a bubble enters stage 1
//   stall_cnt    out  CNT_W           saturating count of stalled cycles
// BEHAVIOUR
//   - Stage entry: {valid, rd, regwrite, is_load}. Each cycle stage k+1 <= stage k.
//     Stage 1 <= decode fields when id_valid & ~stall & ~flush & ~flush_all; else bubble (valid=0).
//     The entry leaving stage DEPTH is dropped. The register file writes first-half/reads second.
//   - Match on port p at stage k: id_src_used[p] & valid_k & regwrite_k & rd_k==src_p & src_p!=0.
//   - fwd_sel[p] = smallest matching k (youngest wins); 0 when there is no match or src_p==0.
//     Combinational from current inputs and state; zero cycles of latency.
//   - Load-use: the youngest match on any port has is_load & k<LOAD_READY -> stall=1, gated by
//     id_valid. Only the youngest match is checked; an older load behind a younger ALU match does
//     not stall. stall is combinational and stays asserted until the load reaches LOAD_READY.
//     With defaults, a single bubble is inserted.
//   - fwd_sel is still driven during stall, but the datapath ignores it because the decode slot
//     does not advance.
//   - flush: the decode instruction is not recorded; stall is still reported but has no extra effect.
//   - flush_all: all stages are invalid on the next edge and outweighs every other input.
//     stall_cnt is not affected.
//   - stall_cnt increments on each edge where stall=1 and rst_n=1. It holds at 2^CNT_W-1.
//   - Reset (rst_n=0 at edge): all stages invalid, stall_cnt=0. The next cycle gives fwd_sel=0
//     and stall=0 on every port. Reset mid-stall drops the hazard; it is not replayed.
//   - No X propagation: invalid stages never match, whatever their rd and flag bits hold.
// TESTING
//   1 Reset, then src={5,6} used -> fwd_sel={0,0}, stall=0, stall_cnt=0.
//   2 add r5 decoded at cycle t; at t+1 a consumer with src0=r5 -> fwd_sel[0]=1. At t+2 -> 2,
//     at t+3 -> 3, at t+4 -> 0.
//   3 lw r7 then a consumer of r7 in the next cycle -> stall=1 for 1 cycle, bubble in stage 1,
//     stall_cnt=1. The next cycle gives fwd_sel=2 and stall=0.
//   4 add r3; add r3; then a consumer of r3 on both ports -> fwd_sel={1,1}.
//     If it instead uses r0 with a producer of r0 in flight -> fwd_sel=0, stall=0.
//   5 lw r4 in stage 1 and a consumer of r4 while flush_all=1 -> next cycle all stages are
//     invalid and the re-issued consumer gets fwd_sel=0. flush alone -> the decode rd is absent
//     from stage 1.
//   6 CNT_W=4 with 20 forced load-use stalls -> stall_cnt=15 and it holds. rst_n=0 during a
//     stall -> stall_cnt=0 and stall=0 on the next cycle.

Source files
------------

// File: rtl/fwd_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : fwd_scoreboard
//  Purpose  : Forwarding / load-use hazard unit. A DEPTH-stage shift
//             scoreboard records the destination of every in-flight
//             instruction; each decode source operand is steered to the
//             youngest in-flight producer (or the register file), load-use
//             hazards raise stall, and stalled cycles are counted.
//  Ports    : clk, rst_n (sync, active-low)
//             id_valid/id_rd/id_regwrite/id_is_load : decode instruction
//             id_src/id_src_used                    : decode source operands
//             flush      : squash decode instruction
//             flush_all  : squash decode and every scoreboard stage
//             fwd_sel    : per port 0=regfile, k=stage k result
//             stall      : hold PC and IF/ID, bubble into stage 1
//             stall_cnt  : saturating stalled-cycle count
//  Revision : 1.0  initial release
// ============================================================================
module fwd_scoreboard #(
    parameter int REG_AW     = 5,
    parameter int NPORTS     = 2,
    parameter int DEPTH      = 3,
    parameter int LOAD_READY = 2,
    parameter int CNT_W      = 16,
    localparam int SEL_W     = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     id_valid,
    input  logic [REG_AW-1:0]        id_rd,
    input  logic                     id_regwrite,
    input  logic                     id_is_load,
    input  logic [NPORTS*REG_AW-1:0] id_src,
    input  logic [NPORTS-1:0]        id_src_used,
    input  logic                     flush,
    input  logic                     flush_all,
    output logic [NPORTS*SEL_W-1:0]  fwd_sel,
    output logic                     stall,
    output logic [CNT_W-1:0]         stall_cnt
);

    // Scoreboard stages, index 1 = ID/EX (youngest) .. DEPTH = oldest.
    logic [DEPTH:1]      r_valid;
    logic [DEPTH:1]      r_regwrite;
    logic [DEPTH:1]      r_is_load;
    logic [REG_AW-1:0]   r_rd [1:DEPTH];
    logic [CNT_W-1:0]    r_stall_cnt;

    logic [NPORTS-1:0]   w_port_hz;
    logic                w_stall;
    logic                w_enter;

    generate
        for (genvar p = 0; p < NPORTS; p++) begin : g_port
            logic [REG_AW-1:0] w_src;
            logic [SEL_W-1:0]  w_sel;
            logic              w_hz;

            assign w_src = id_src[p*REG_AW +: REG_AW];

            // Scan oldest to youngest so the youngest match overwrites.
            // Only the youngest matching stage decides the hazard.
            always_comb begin
                w_sel = '0;
                w_hz  = 1'b0;
                for (int k = DEPTH; k >= 1; k--) begin
                    if (id_src_used[p] && r_valid[k] && r_regwrite[k] &&
                        (r_rd[k] == w_src) && (w_src != '0)) begin
                        w_sel = SEL_W'(k);
                        w_hz  = r_is_load[k] && (k < LOAD_READY);
                    end
                end
            end

            assign fwd_sel[p*SEL_W +: SEL_W] = w_sel;
            assign w_port_hz[p]              = w_hz;
        end
    endgenerate

    assign w_stall   = id_valid && (|w_port_hz);
    assign w_enter   = id_valid && !w_stall && !flush && !flush_all;
    assign stall     = w_stall;
    assign stall_cnt = r_stall_cnt;

    // Valid bits and the counter carry reset; the payload does not need it
    // because an invalid stage never matches.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid     <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (flush_all) begin
                r_valid <= '0;
            end else begin
                for (int k = DEPTH; k >= 2; k--) begin
                    r_valid[k] <= r_valid[k-1];
                end
                r_valid[1] <= w_enter;
            end
            if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int k = DEPTH; k >= 2; k--) begin
            r_rd[k]       <= r_rd[k-1];
            r_regwrite[k] <= r_regwrite[k-1];
            r_is_load[k]  <= r_is_load[k-1];
        end
        r_rd[1]       <= id_rd;
        r_regwrite[1] <= id_regwrite;
        r_is_load[1]  <= id_is_load;
    end

endmodule
`default_nettype wire
